debug_run_ctrl: RTL and testbench
=================================

# debug_run_ctrl

Execution controller that takes over the CPU once firmware loading is complete. It reads single-byte commands from the UART Rx FIFO and runs the CPU continuously or for one step. After each run it serializes PC and register-file contents into the UART Tx FIFO. It sits between the UART FIFOs, the CPU enable, and the register file's debug read port, beside the firmware loader.

## Interface
- NB_DATA, 8, UART/FIFO byte width
- NB_REG, 32, register and PC width
- N_REGS, 32, registers dumped
- NB_REG_ADDR, 5, debug read address width
- clk  in  1  clock
- i_rst  in  1  reset (synchronous, active-high)
- i_start  in  1  firmware load complete; level or pulse, sampled only in WAIT_LOAD
- i_rx_empty  in  1  Rx FIFO empty
- i_rx_data  in  NB_DATA  Rx FIFO head byte (first-word-fall-through, valid while !i_rx_empty)
- o_rd  out  1  Rx FIFO pop, one-cycle pulse
- i_tx_full  in  1  Tx FIFO full
- o_wr  out  1  Tx FIFO push, one-cycle pulse
- o_wdata  out  NB_DATA  Tx FIFO byte, valid while o_wr
- o_cpu_en  out  1  CPU clock enable
- i_halt  in  1  CPU has decoded its halt instruction (level)
- i_pc  in  NB_REG  current PC
- o_reg_addr  out  NB_REG_ADDR  register-file debug read address
- i_reg_data  in  NB_REG  register data, valid 1 cycle after o_reg_addr
- o_busy  out  1  high in any state other than WAIT_LOAD, CMD_IDLE and HALTED

## Operation
- Commands:
  - 'C' 0x43: continuous run.
  - 'S' 0x53: single step.
  - 'D' 0x44: dump only.
  - Any other byte: reply NAK 0x15, no other effect.
- States:
  - WAIT_LOAD -> CMD_IDLE when i_start is high.
  - CMD_IDLE: when !i_rx_empty, pulse o_rd and decode i_rx_data in the same cycle.
    - 'C' -> RUN.
    - 'S' -> STEP.
    - 'D' -> DUMP_PC.
    - Other byte -> NAK.
  - HALTED: behaves as CMD_IDLE, except 'C' and 'S' reply NAK. Only reset leaves HALTED.
  - RUN: o_cpu_en=1. When i_halt is seen, set the halted flag and go to DUMP_PC.
  - STEP: o_cpu_en=1 for exactly one cycle, then DUMP_PC. If i_halt is already high in CMD_IDLE, 'S' replies NAK instead.
  - NAK: push 0x15 once !i_tx_full, then return to CMD_IDLE, or to HALTED if the halted flag is set.
  - DUMP_PC: latch i_pc on entry, then push its 4 bytes LSB first.
  - REG_FETCH: drive o_reg_addr=r and wait one cycle.
  - REG_SEND: latch i_reg_data and push 4 bytes LSB first.
    - r < N_REGS-1: r++ and return to REG_FETCH.
    - Otherwise go to SEND_EOT.
  - SEND_EOT: push EOT 0x04, then go to CMD_IDLE or HALTED.
- o_cpu_en is decoded from state: it is high only in RUN and STEP.
- The dump is 4 + 4·N_REGS + 1 bytes, which is 133 at the defaults.
- The byte index counter is 8 bits wide. The register index wraps only via the explicit compare; no modulo arithmetic.
- Tx flow control:
  - A byte is pushed only in a cycle with !i_tx_full.
  - Otherwise the byte is held and the sequence stalls.
  - No byte is dropped or duplicated.
- Commands received during RUN, STEP or a dump remain in the Rx FIFO. They are not popped until CMD_IDLE or HALTED.

## Timing
- Reset values:
  - o_cpu_en=0, o_rd=0, o_wr=0, o_wdata=0x00, o_reg_addr=0, o_busy=0.
  - State WAIT_LOAD, halted flag cleared.
- Reset mid-run or mid-dump aborts immediately and returns to WAIT_LOAD.
- Command byte popped at cycle T: o_cpu_en rises at T+1.
- RUN with i_halt high at cycle H: o_cpu_en=0 from H+1.
- STEP: o_cpu_en is high for exactly 1 cycle, and the first dump push is no earlier than 1 cycle later.
- With the Tx FIFO never full, at most one o_wr per cycle. Each register costs 1 fetch cycle plus 4 push cycles.
- i_halt and a rising i_tx_full in the same cycle: the halt takes priority and the dump starts stalled.

## Configuration
- Macro DEBUG_RUN_CTRL_CYCLE_COUNT_EN.
- Defined:
  - Adds a 32-bit counter that increments every cycle o_cpu_en=1. It saturates at 0xFFFFFFFF and clears only on reset.
  - Its 4 bytes, LSB first, are inserted after the PC bytes, making the dump 137 bytes.
- Undefined: no counter, and the dump is 133 bytes.

## Test plan
- Reset, i_start=1, then Rx byte 'D' with PC=0x00000010 and regs r[i]=i. Required Tx stream: 10 00 00 00, then 00 00 00 00, 01 00 00 00 … 1F 00 00 00, then 04 (133 bytes); o_cpu_en stays 0.
- 'S' with i_halt=0 -> o_cpu_en high exactly 1 cycle, then a 133-byte dump ending in 0x04.
- 'C' with i_halt raised after 20 cycles -> o_cpu_en high 20 cycles and low the cycle after the halt, then a dump. Following 'C' and 'S' each reply 0x15, and 'D' still dumps.
- Rx byte 0x7A -> single 0x15 pushed, state unchanged, o_cpu_en=0.
- During the dump, i_tx_full toggles high for 3 cycles every 5 -> the byte stream is identical to the unstalled case, with no o_wr while full.
- i_rst asserted mid-dump at byte 50 -> all outputs return to reset values next cycle; commands are ignored until i_start.

Source files
------------

// File: rtl/debug_run_ctrl.sv
// debug_run_ctrl: UART command controller that runs/steps the CPU and dumps PC plus register file.
// Define DEBUG_RUN_CTRL_CYCLE_COUNT_EN to append a saturating run-cycle counter after the PC bytes.
module debug_run_ctrl #(
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned NB_REG      = 32,
  parameter int unsigned N_REGS      = 32,
  parameter int unsigned NB_REG_ADDR = 5
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_rx_empty,
  input  logic [NB_DATA-1:0]     i_rx_data,
  output logic                   o_rd,
  input  logic                   i_tx_full,
  output logic                   o_wr,
  output logic [NB_DATA-1:0]     o_wdata,
  output logic                   o_cpu_en,
  input  logic                   i_halt,
  input  logic [NB_REG-1:0]      i_pc,
  output logic [NB_REG_ADDR-1:0] o_reg_addr,
  input  logic [NB_REG-1:0]      i_reg_data,
  output logic                   o_busy
);

  localparam int unsigned NB_CNT = 8;
  localparam int unsigned NB_SEL = 2;

  localparam logic [NB_DATA-1:0]     CMD_CONT     = NB_DATA'(8'h43);
  localparam logic [NB_DATA-1:0]     CMD_STEP     = NB_DATA'(8'h53);
  localparam logic [NB_DATA-1:0]     CMD_DUMP     = NB_DATA'(8'h44);
  localparam logic [NB_DATA-1:0]     BYTE_NAK     = NB_DATA'(8'h15);
  localparam logic [NB_DATA-1:0]     BYTE_EOT     = NB_DATA'(8'h04);
  localparam logic [NB_CNT-1:0]      PC_LAST_BYTE = NB_CNT'(3);
  localparam logic [NB_REG_ADDR-1:0] REG_LAST     = NB_REG_ADDR'(N_REGS - 1);
`ifdef DEBUG_RUN_CTRL_CYCLE_COUNT_EN
  localparam logic [NB_CNT-1:0]      CYC_LAST_BYTE = NB_CNT'(7);
`endif

  typedef enum logic [3:0] {
    WAIT_LOAD,
    CMD_IDLE,
    HALTED,
    RUN,
    STEP,
    NAK,
    DUMP_PC,
`ifdef DEBUG_RUN_CTRL_CYCLE_COUNT_EN
    DUMP_CYC,
`endif
    REG_FETCH,
    REG_SEND,
    SEND_EOT
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  state_t                   w_ret_state;
  logic                     r_halted;
  logic [NB_REG-1:0]        r_word;
  logic [NB_CNT-1:0]        r_byte_cnt;
  logic [NB_REG_ADDR-1:0]   r_reg_idx;
  logic [NB_SEL-1:0]        w_sel;
  logic                     w_push;
  logic                     w_is_word;
  logic [NB_REG-1:0]        w_live;
  logic [NB_REG-1:0]        w_word;
  logic [NB_DATA-1:0]       w_byte;
  logic                     w_dump_entry;
`ifdef DEBUG_RUN_CTRL_CYCLE_COUNT_EN
  logic [NB_REG-1:0]        r_cyc_cnt;
`endif

  assign w_sel = r_byte_cnt[NB_SEL-1:0];

  // Next state, Rx pop and Tx byte selection; byte 0 of each word comes straight from its source.
  always_comb begin
    w_state_next = r_state;
    w_ret_state  = r_halted ? HALTED : CMD_IDLE;
    o_rd         = 1'b0;
    w_push       = 1'b0;
    w_is_word    = 1'b0;
    w_live       = '0;
    w_byte       = '0;
    case (r_state)
      WAIT_LOAD: if (i_start) w_state_next = CMD_IDLE;
      CMD_IDLE, HALTED: begin
        if (!i_rx_empty) begin
          o_rd = 1'b1;
          case (i_rx_data)
            CMD_CONT: w_state_next = (r_state == HALTED) ? NAK : RUN;
            CMD_STEP: w_state_next = (r_state == HALTED || i_halt) ? NAK : STEP;
            CMD_DUMP: w_state_next = DUMP_PC;
            default:  w_state_next = NAK;
          endcase
        end
      end
      RUN:  if (i_halt) w_state_next = DUMP_PC;
      STEP: w_state_next = DUMP_PC;
      NAK: begin
        w_push = !i_tx_full;
        w_byte = BYTE_NAK;
        if (!i_tx_full) w_state_next = w_ret_state;
      end
      DUMP_PC: begin
        w_is_word = 1'b1;
        w_push    = !i_tx_full;
        w_live    = i_pc;
`ifdef DEBUG_RUN_CTRL_CYCLE_COUNT_EN
        if (w_push && r_byte_cnt == PC_LAST_BYTE) w_state_next = DUMP_CYC;
      end
      DUMP_CYC: begin
        w_is_word = 1'b1;
        w_push    = !i_tx_full;
        w_live    = r_cyc_cnt;
        if (w_push && r_byte_cnt == CYC_LAST_BYTE) w_state_next = REG_FETCH;
`else
        if (w_push && r_byte_cnt == PC_LAST_BYTE) w_state_next = REG_FETCH;
`endif
      end
      REG_FETCH: w_state_next = REG_SEND;
      REG_SEND: begin
        w_is_word = 1'b1;
        w_push    = !i_tx_full;
        w_live    = i_reg_data;
        if (w_push && w_sel == '1)
          w_state_next = (r_reg_idx == REG_LAST) ? SEND_EOT : REG_FETCH;
      end
      SEND_EOT: begin
        w_push = !i_tx_full;
        w_byte = BYTE_EOT;
        if (!i_tx_full) w_state_next = w_ret_state;
      end
      default: w_state_next = WAIT_LOAD;
    endcase
    w_word = (w_sel == '0) ? w_live : r_word;
    if (w_is_word) w_byte = w_word[NB_DATA*w_sel +: NB_DATA];
  end

  assign w_dump_entry = (w_state_next == DUMP_PC) && (r_state != DUMP_PC);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state    <= WAIT_LOAD;
      r_halted   <= 1'b0;
      r_word     <= '0;
      r_byte_cnt <= '0;
      r_reg_idx  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == RUN && i_halt) r_halted <= 1'b1;
      if (w_dump_entry) begin
        r_byte_cnt <= '0;
        r_reg_idx  <= '0;
      end else if (w_push && w_is_word) begin
        r_byte_cnt <= r_byte_cnt + NB_CNT'(1);
        if (w_sel == '0) r_word <= w_live;
        if (r_state == REG_SEND && w_sel == '1 && r_reg_idx != REG_LAST)
          r_reg_idx <= r_reg_idx + NB_REG_ADDR'(1);
      end
    end
  end

`ifdef DEBUG_RUN_CTRL_CYCLE_COUNT_EN
  // Counts CPU-enabled cycles since reset, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (i_rst)                         r_cyc_cnt <= '0;
    else if (o_cpu_en && r_cyc_cnt != '1) r_cyc_cnt <= r_cyc_cnt + NB_REG'(1);
  end
`endif

  assign o_wr       = w_push;
  assign o_wdata    = w_push ? w_byte : '0;
  assign o_cpu_en   = (r_state == RUN) || (r_state == STEP);
  assign o_busy     = !((r_state == WAIT_LOAD) || (r_state == CMD_IDLE) || (r_state == HALTED));
  assign o_reg_addr = r_reg_idx;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Directed self-checking bench for debug_run_ctrl: Rx/Tx FIFO and register-file models around the DUT.
`timescale 1ns/1ps
module tb_debug_run_ctrl;

  localparam int unsigned NB_DATA     = 8;
  localparam int unsigned NB_REG      = 32;
  localparam int unsigned N_REGS      = 32;
  localparam int unsigned NB_REG_ADDR = 5;
`ifdef DEBUG_RUN_CTRL_CYCLE_COUNT_EN
  localparam int DUMP_LEN = 4 + 4 + 4 * N_REGS + 1;
`else
  localparam int DUMP_LEN = 4 + 4 * N_REGS + 1;
`endif
  localparam logic [31:0] PC_VAL = 32'h0000_0010;

  logic                   clk = 1'b0;
  logic                   i_rst = 1'b1;
  logic                   i_start = 1'b0;
  logic                   i_rx_empty = 1'b1;
  logic [NB_DATA-1:0]     i_rx_data = '0;
  logic                   o_rd;
  logic                   i_tx_full = 1'b0;
  logic                   o_wr;
  logic [NB_DATA-1:0]     o_wdata;
  logic                   o_cpu_en;
  logic                   i_halt = 1'b0;
  logic [NB_REG-1:0]      i_pc = PC_VAL;
  logic [NB_REG_ADDR-1:0] o_reg_addr;
  logic [NB_REG-1:0]      i_reg_data = '0;
  logic                   o_busy;

  debug_run_ctrl #(
    .NB_DATA(NB_DATA), .NB_REG(NB_REG), .N_REGS(N_REGS), .NB_REG_ADDR(NB_REG_ADDR)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_rx_empty(i_rx_empty), .i_rx_data(i_rx_data), .o_rd(o_rd),
    .i_tx_full(i_tx_full), .o_wr(o_wr), .o_wdata(o_wdata),
    .o_cpu_en(o_cpu_en), .i_halt(i_halt), .i_pc(i_pc),
    .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] expq[$];
  logic       rd_s = 1'b0;
  logic       cpu_prev = 1'b0;
  logic       stall_en = 1'b0;
  int         stall_ph = 0;
  int         cyc = 0;
  int         rd_cyc = 0;
  int         rise_cyc = 0;
  int         fall_cyc = 0;
  int         last_cpu_cyc = 0;
  int         first_wr_cyc = -1;
  int         cpu_cnt = 0;
  int         cpu_total = 0;
  int         wr_full_err = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  // Mid-cycle observation of the DUT outputs.
  always @(negedge clk) begin
    cyc = cyc + 1;
    rd_s = o_rd;
    if (o_rd) rd_cyc = cyc;
    if (i_rst) cpu_total = 0;
    else if (o_cpu_en) cpu_total = cpu_total + 1;
    if (o_cpu_en) begin
      cpu_cnt = cpu_cnt + 1;
      last_cpu_cyc = cyc;
    end
    if (o_cpu_en && !cpu_prev) rise_cyc = cyc;
    if (!o_cpu_en && cpu_prev) fall_cyc = cyc;
    cpu_prev = o_cpu_en;
    if (o_wr) begin
      txq.push_back(o_wdata);
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (i_tx_full) wr_full_err = wr_full_err + 1;
    end
  end

  // FWFT Rx FIFO, registered register file (r[i] = i) and Tx backpressure pattern.
  always @(posedge clk) begin
    if (rd_s && rxq.size() > 0) rxq.delete(0);
    i_rx_empty <= (rxq.size() == 0);
    i_rx_data  <= (rxq.size() == 0) ? 8'h00 : rxq[0];
    i_reg_data <= 32'(o_reg_addr);
    stall_ph   <= (stall_ph == 4) ? 0 : stall_ph + 1;
    i_tx_full  <= stall_en && (stall_ph < 3);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k;
    k = 0;
    while (txq.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    tick(4);
  endtask

  function automatic void build_exp(input logic [31:0] pc, input logic [31:0] cc);
    logic [31:0] rv;
    expq.delete();
    for (int b = 0; b < 4; b++) expq.push_back(pc[8*b +: 8]);
`ifdef DEBUG_RUN_CTRL_CYCLE_COUNT_EN
    for (int b = 0; b < 4; b++) expq.push_back(cc[8*b +: 8]);
`else
    if (cc == 32'hFFFF_FFFF) rv = '0;
`endif
    for (int r = 0; r < int'(N_REGS); r++) begin
      rv = 32'(r);
      for (int b = 0; b < 4; b++) expq.push_back(rv[8*b +: 8]);
    end
    expq.push_back(8'h04);
  endfunction

  // -2: length differs, -1: identical, otherwise index of first differing byte.
  function automatic int first_diff();
    if (txq.size() != expq.size()) return -2;
    foreach (expq[i]) if (txq[i] !== expq[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    logic [16:0] obs;
    i_rst = 1'b1;
    tick(2);
    obs = {o_cpu_en, o_rd, o_wr, o_busy, o_wdata, o_reg_addr};
    n_checks++;
    if (obs !== 17'h0) $display("FAIL reset_outputs got %h expected %h", obs, 17'h0);
    else n_pass++;
    i_rst = 1'b0;
    rxq.push_back(8'h44);
    tick(8);
    n_checks++;
    if ({32'(rxq.size()), 32'(txq.size())} !== {32'd1, 32'd0})
      $display("FAIL ignore_before_start rx=%0d tx=%0d expected rx=1 tx=0", rxq.size(), txq.size());
    else n_pass++;
    // The queued 'D' is consumed once start is seen.
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic test_dump();
    int c0;
    int d;
    c0 = cpu_cnt;
    wait_tx(DUMP_LEN, 400);
    build_exp(PC_VAL, 32'(cpu_total));
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL dump_stream diff_at=%0d len=%0d expected len=%0d", d, txq.size(), DUMP_LEN);
    else n_pass++;
    n_checks++;
    if (cpu_cnt - c0 !== 0) $display("FAIL dump_cpu_en cycles=%0d expected 0", cpu_cnt - c0);
    else n_pass++;
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL dump_idle_busy got %b expected 0", o_busy);
    else n_pass++;
  endtask

  task automatic test_step();
    int c0;
    int d;
    txq.delete();
    first_wr_cyc = -1;
    c0 = cpu_cnt;
    rxq.push_back(8'h53);
    wait_tx(DUMP_LEN, 400);
    n_checks++;
    if (cpu_cnt - c0 !== 1) $display("FAIL step_cpu_cycles got %0d expected 1", cpu_cnt - c0);
    else n_pass++;
    n_checks++;
    if (rise_cyc - rd_cyc !== 1) $display("FAIL step_cpu_latency got %0d expected 1", rise_cyc - rd_cyc);
    else n_pass++;
    n_checks++;
    if (!(first_wr_cyc > last_cpu_cyc))
      $display("FAIL step_dump_after_cpu first_wr=%0d cpu=%0d expected first_wr later", first_wr_cyc, last_cpu_cyc);
    else n_pass++;
    build_exp(PC_VAL, 32'(cpu_total));
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL step_stream diff_at=%0d len=%0d expected len=%0d", d, txq.size(), DUMP_LEN);
    else n_pass++;
  endtask

  task automatic test_nak();
    int c0;
    logic [7:0] b;
    txq.delete();
    c0 = cpu_cnt;
    rxq.push_back(8'h7A);
    wait_tx(1, 20);
    b = (txq.size() > 0) ? txq[0] : 8'hxx;
    n_checks++;
    if (txq.size() !== 1) $display("FAIL nak_count got %0d expected 1", txq.size());
    else n_pass++;
    n_checks++;
    if (b !== 8'h15) $display("FAIL nak_byte got %h expected 15", b);
    else n_pass++;
    n_checks++;
    if ({cpu_cnt - c0, 31'(0), o_busy} !== 64'h0)
      $display("FAIL nak_no_effect cpu=%0d busy=%b expected 0 0", cpu_cnt - c0, o_busy);
    else n_pass++;
  endtask

  task automatic test_stall();
    int d;
    txq.delete();
    wr_full_err = 0;
    stall_en = 1'b1;
    rxq.push_back(8'h44);
    wait_tx(DUMP_LEN, 1000);
    stall_en = 1'b0;
    tick(2);
    build_exp(PC_VAL, 32'(cpu_total));
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL stall_stream diff_at=%0d len=%0d expected len=%0d", d, txq.size(), DUMP_LEN);
    else n_pass++;
    n_checks++;
    if (wr_full_err !== 0) $display("FAIL stall_wr_while_full got %0d expected 0", wr_full_err);
    else n_pass++;
  endtask

  task automatic test_run_halt();
    int c0;
    int k;
    int d;
    txq.delete();
    c0 = cpu_cnt;
    rxq.push_back(8'h43);
    k = 0;
    while (!o_cpu_en && k < 20) begin
      tick(1);
      k++;
    end
    tick(19);
    i_halt = 1'b1;
    wait_tx(DUMP_LEN, 400);
    n_checks++;
    if (cpu_cnt - c0 !== 20) $display("FAIL run_cpu_cycles got %0d expected 20", cpu_cnt - c0);
    else n_pass++;
    n_checks++;
    if (fall_cyc - rise_cyc !== 20) $display("FAIL run_cpu_fall got %0d expected 20", fall_cyc - rise_cyc);
    else n_pass++;
    build_exp(PC_VAL, 32'(cpu_total));
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL run_stream diff_at=%0d len=%0d expected len=%0d", d, txq.size(), DUMP_LEN);
    else n_pass++;
    // Halted: run and step are refused, dump still works.
    txq.delete();
    c0 = cpu_cnt;
    rxq.push_back(8'h43);
    wait_tx(1, 20);
    rxq.push_back(8'h53);
    wait_tx(2, 20);
    n_checks++;
    if (txq.size() !== 2 || txq[0] !== 8'h15 || txq[1] !== 8'h15)
      $display("FAIL halted_nak len=%0d expected 2 bytes of 15", txq.size());
    else n_pass++;
    n_checks++;
    if ({cpu_cnt - c0, 31'(0), o_busy} !== 64'h0)
      $display("FAIL halted_idle cpu=%0d busy=%b expected 0 0", cpu_cnt - c0, o_busy);
    else n_pass++;
    txq.delete();
    rxq.push_back(8'h44);
    wait_tx(DUMP_LEN, 400);
    build_exp(PC_VAL, 32'(cpu_total));
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL halted_dump diff_at=%0d len=%0d expected len=%0d", d, txq.size(), DUMP_LEN);
    else n_pass++;
  endtask

  task automatic test_reset_mid_dump();
    logic [16:0] obs;
    int k;
    int c0;
    int d;
    txq.delete();
    rxq.push_back(8'h44);
    k = 0;
    while (txq.size() < 50 && k < 300) begin
      tick(1);
      k++;
    end
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    obs = {o_cpu_en, o_rd, o_wr, o_busy, o_wdata, o_reg_addr};
    n_checks++;
    if (obs !== 17'h0) $display("FAIL rst_mid_dump_outputs got %h expected %h", obs, 17'h0);
    else n_pass++;
    txq.delete();
    c0 = cpu_cnt;
    rxq.push_back(8'h53);
    tick(8);
    n_checks++;
    if ({32'(rxq.size()), 32'(txq.size()), cpu_cnt - c0} !== {32'd1, 32'd0, 32'd0})
      $display("FAIL rst_ignore rx=%0d tx=%0d cpu=%0d expected 1 0 0", rxq.size(), txq.size(), cpu_cnt - c0);
    else n_pass++;
    i_halt = 1'b0;
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    wait_tx(DUMP_LEN, 400);
    n_checks++;
    if (cpu_cnt - c0 !== 1) $display("FAIL rst_clears_halted cpu=%0d expected 1", cpu_cnt - c0);
    else n_pass++;
    build_exp(PC_VAL, 32'(cpu_total));
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL rst_step_stream diff_at=%0d len=%0d expected len=%0d", d, txq.size(), DUMP_LEN);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_dump();
    test_step();
    test_nak();
    test_stall();
    test_run_halt();
    test_reset_mid_dump();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
